// File: rtl/genram3.sv
// Single-port word RAM with per-byte write enables and a 1-cycle registered read.
// After reset it sweeps CLR_VAL into every location and holds busy until the sweep is done.
module genram3 #(
  parameter int              AW      = 4,
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            rw,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   data_in,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   data_out,
  output logic            valid,
  output logic            busy
);

  localparam int DEPTH = 2 ** AW;
  localparam int NB    = DW / 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic [DW-1:0]   mem_q [0:DEPTH-1];

  logic            we_s;
  logic [AW-1:0]   waddr_s;
  logic [DW-1:0]   wdata_s;
  logic [DW-1:0]   wmask_s;

  // Next-state, request decode and memory write port selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    data_out_d = data_out_q;
    we_s       = 1'b0;
    waddr_s    = cnt_q;
    wdata_s    = CLR_VAL;
    wmask_s    = {DW{1'b0}};
    case (state_q)
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cnt_q;
        wdata_s = CLR_VAL;
        wmask_s = {DW{1'b1}};
        cnt_d   = cnt_q + AW'(1'b1);
        if (cnt_q == {AW{1'b1}}) begin
          state_d = READY;
          busy_d  = 1'b0;
        end else begin
          state_d = CLEAR;
          busy_d  = 1'b1;
        end
      end
      READY: begin
        if (en && rw) begin
          data_out_d = mem_q[addr];
          valid_d    = 1'b1;
        end else if (en) begin
          // Byte lanes whose be bit is 0 keep their stored value
          we_s    = 1'b1;
          waddr_s = addr;
          wdata_s = data_in;
          for (int i = 0; i < NB; i++) begin
            wmask_s[8*i +: 8] = {8{be[i]}};
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {AW{1'b0}};
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= {AW{1'b0}};
      busy_q     <= 1'b1;
      valid_q    <= 1'b0;
      data_out_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array; writes are suppressed while rst is held
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_q[waddr_s] <= (mem_q[waddr_s] & ~wmask_s) | (wdata_s & wmask_s);
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_genram3.sv
// Directed self-checking bench for genram3 with AW=4, DW=32, CLR_VAL=0.
module tb_genram3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rw;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  be;
  logic [31:0] data_out;
  logic        valid;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;
  int n;

  genram3 #(.AW(4), .DW(32), .CLR_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr),
    .data_in(data_in), .be(be), .data_out(data_out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts edges until busy drops, bounded at 40
  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    en = 1'b1; rw = 1'b0; addr = a; data_in = d; be = b;
    step();
  endtask

  task automatic rd(input logic [3:0] a);
    en = 1'b1; rw = 1'b1; addr = a;
    step();
  endtask

  task automatic idle();
    en = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b0; addr = 4'd0; data_in = 32'h0; be = 4'h0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", data_out, 32'h0000_0000);

    // Write request held during the sweep must be ignored
    rst = 1'b0;
    en = 1'b1; rw = 1'b0; addr = 4'd3; data_in = 32'h1234_5678; be = 4'hF;
    wait_sweep(n);
    en = 1'b0;
    chk("sweep_len", n, 32'd16);
    chk("busy_low", {31'd0, busy}, 32'd0);

    rd(4'd5);
    chk("rd5_valid", {31'd0, valid}, 32'd1);
    chk("rd5_data", data_out, 32'h0000_0000);
    idle();
    chk("idle_valid", {31'd0, valid}, 32'd0);
    rd(4'd3);
    chk("rd3_ignored_wr", data_out, 32'h0000_0000);

    wr(4'd1, 32'hFFFF_FFFF, 4'hF);
    chk("wr_valid", {31'd0, valid}, 32'd0);
    rd(4'd1);
    chk("rd1_full", data_out, 32'hFFFF_FFFF);
    chk("rd1_valid", {31'd0, valid}, 32'd1);

    wr(4'd2, 32'hAABB_CCDD, 4'b0101);
    rd(4'd2);
    chk("rd2_partial", data_out, 32'h00BB_00DD);
    wr(4'd2, 32'h1122_3344, 4'b0000);
    chk("be0_hold_data", data_out, 32'h00BB_00DD);
    rd(4'd2);
    chk("rd2_be0", data_out, 32'h00BB_00DD);
    idle();
    chk("idle_hold", data_out, 32'h00BB_00DD);

    // Back-to-back reads
    wr(4'd1, 32'h0000_0001, 4'hF);
    wr(4'd2, 32'h0000_0002, 4'hF);
    wr(4'd3, 32'h0000_0003, 4'hF);
    rd(4'd1);
    chk("b2b_1", data_out, 32'h0000_0001);
    chk("b2b_1v", {31'd0, valid}, 32'd1);
    rd(4'd2);
    chk("b2b_2", data_out, 32'h0000_0002);
    chk("b2b_2v", {31'd0, valid}, 32'd1);
    rd(4'd3);
    chk("b2b_3", data_out, 32'h0000_0003);
    chk("b2b_3v", {31'd0, valid}, 32'd1);
    idle();
    chk("b2b_end_v", {31'd0, valid}, 32'd0);
    chk("b2b_end_hold", data_out, 32'h0000_0003);

    // Reset in READY clears memory again
    wr(4'd1, 32'hFFFF_FFFF, 4'hF);
    en = 1'b0; rst = 1'b1;
    step();
    chk("rst2_busy", {31'd0, busy}, 32'd1);
    chk("rst2_data", data_out, 32'h0000_0000);
    rst = 1'b0;
    wait_sweep(n);
    chk("sweep2_len", n, 32'd16);
    rd(4'd1);
    chk("rd1_cleared", data_out, 32'h0000_0000);

    // Reset during a read aborts it
    wr(4'd4, 32'hCAFE_F00D, 4'hF);
    en = 1'b1; rw = 1'b1; addr = 4'd4; rst = 1'b1;
    step();
    chk("rd_abort_valid", {31'd0, valid}, 32'd0);
    chk("rd_abort_data", data_out, 32'h0000_0000);

    // Reset at sweep cycle 7 restarts the full sweep
    en = 1'b0; rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_sweep(n);
    chk("sweep3_len", n, 32'd16);
    rd(4'd2);
    chk("rd2_cleared", data_out, 32'h0000_0000);
    rd(4'd4);
    chk("rd4_cleared", data_out, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
